clk_gate_ctrl: RTL
==================

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 SHALL have parameter NumDomains, default 4, the number of gated clock domains (1..16).
REQ-002 SHALL have parameter IdleCycles, default 16, the consecutive quiet cycles before a domain is gated (>=1).
REQ-003 SHALL have parameter WakeCycles, default 2, the cycles with enable high before wake is acknowledged (>=1).
REQ-004 SHALL have port clk_i, input, 1, the single ungated controller clock.
REQ-005 SHALL have port rst_ni, input, 1, the reset; one clock, reset asynchronous active-low.
REQ-006 SHALL have port force_on_i, input, 1, a global request that keeps all domains ungated.
REQ-007 SHALL have port busy_i, input, NumDomains, per-domain activity indication.
REQ-008 SHALL have port wake_req_i, input, NumDomains, per-domain wake request, held high until acknowledged.
REQ-009 SHALL have port wake_ack_o, output, NumDomains, per-domain wake acknowledge.
REQ-010 SHALL have port en_o, output, NumDomains, per-domain enable driving the en_i input of one clk_gate instance.
REQ-011 SHALL have port gated_o, output, NumDomains, a per-domain status flag that is high while the domain state is GATED or PEND.

Function
REQ-012 SHALL define per-domain quiet[d] = !busy_i[d] & !wake_req_i[d] & !force_on_i.
REQ-013 SHALL hold per domain an FSM with states RUN, GATED, PEND and WAKE, an idle counter of width $clog2(IdleCycles+1), and a wake counter of width $clog2(WakeCycles+1).
REQ-014 SHALL, in RUN: en_o[d]=1; idle counter increments each quiet cycle, saturating; it clears on any non-quiet cycle.
REQ-015 SHALL move RUN->GATED on the quiet cycle in which the idle counter equals IdleCycles-1; en_o[d] falls on the next edge, i.e. exactly IdleCycles quiet cycles after the last activity.
REQ-016 SHALL, in GATED: en_o[d]=0; any non-quiet cycle moves GATED->PEND.
REQ-017 SHALL, in PEND: en_o[d]=0; the state waits for a wake grant.
REQ-018 SHALL grant wakes with a round-robin arbiter: at most one PEND domain per cycle; search starts at last-granted index+1 and wraps modulo NumDomains.
REQ-019 SHALL move a granted domain PEND->WAKE on the next edge, with its wake counter cleared.
REQ-020 SHALL, in WAKE: en_o[d]=1; the wake counter increments; the state moves WAKE->RUN on the cycle the counter equals WakeCycles-1, clearing the idle counter.
REQ-021 SHALL drive wake_ack_o[d] = wake_req_i[d] & (state==RUN), combinationally.
REQ-022 SHALL let a wake_req_i deassertion during PEND or WAKE abort nothing; the sequence completes to RUN, then idle counting resumes.
REQ-023 SHALL ignore busy_i and wake_req_i while the domain is in WAKE.
REQ-024 SHALL, with force_on_i high, keep RUN domains in RUN and move all GATED domains to PEND; wakes remain staggered one grant per cycle.
REQ-025 SHALL register every en_o bit as a flop output, so it is glitch-free into clk_gate.
REQ-026 SHALL resolve a simultaneous non-quiet input and counter terminal value in RUN in favour of staying in RUN.

Reset
REQ-027 SHALL, while rst_ni=0, asynchronously force all domains to RUN, en_o to all-ones, gated_o to 0, wake_ack_o to 0, all counters to 0, and the round-robin pointer to NumDomains-1, so domain 0 has first priority.
REQ-028 SHALL, on reset assertion mid-WAKE or mid-PEND, abandon the sequence and place the domain in RUN with no residual grant.
REQ-029 SHALL resume normal operation from the first rising clk_i edge after rst_ni rises.

Verification
REQ-030 SHALL verify the idle timeout: defaults; hold all inputs 0 after reset -> en_o=4'b1111 for 16 edges, then 4'b0000 and gated_o=4'b1111 at edge 16.
REQ-031 SHALL verify the wake handshake: with domain 2 GATED, raise wake_req_i[2] -> PEND for 1 cycle, en_o[2]=1 for 2 WAKE cycles, then wake_ack_o[2]=1 in RUN; drop the request -> ack drops the same cycle.
REQ-032 SHALL verify wake staggering: all domains GATED, pulse force_on_i high -> en_o bits rise on consecutive edges in order 0,1,2,3, never two in one cycle.
REQ-033 SHALL verify round-robin fairness: last grant to domain 1; domains 0 and 3 PEND together -> domain 3 is granted first, then domain 0.
REQ-034 SHALL verify busy reset of the idle count: in RUN, busy_i[0]=1 at quiet cycle 15 -> the counter clears and en_o[0] stays 1 for 16 further quiet cycles.
REQ-035 SHALL verify async reset mid-wake: assert rst_ni=0 between edges while domain 1 is in WAKE -> en_o immediately 4'b1111, all counters 0, and domain 0 is granted first after reset.

Source files
------------

// File: rtl/clk_gate_ctrl.sv
// Per-domain clock-gate controller: idle timeout gating, round-robin staggered
// wake-up, and a registered enable per domain for an external clk_gate cell.
module clk_gate_ctrl #(
    parameter int unsigned NumDomains = 4,
    parameter int unsigned IdleCycles = 16,
    parameter int unsigned WakeCycles = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  force_on_i,
    input  logic [NumDomains-1:0] busy_i,
    input  logic [NumDomains-1:0] wake_req_i,
    output logic [NumDomains-1:0] wake_ack_o,
    output logic [NumDomains-1:0] en_o,
    output logic [NumDomains-1:0] gated_o
);

    localparam int unsigned IdleW = $clog2(IdleCycles + 1);
    localparam int unsigned WakeW = $clog2(WakeCycles + 1);
    localparam int unsigned PtrW  = (NumDomains > 1) ? $clog2(NumDomains) : 1;

    localparam logic [IdleW-1:0] IdleLast = IdleW'(IdleCycles - 1);
    localparam logic [IdleW-1:0] IdleMax  = IdleW'(IdleCycles);
    localparam logic [WakeW-1:0] WakeLast = WakeW'(WakeCycles - 1);
    localparam logic [PtrW-1:0]  PtrInit  = PtrW'(NumDomains - 1);

    typedef enum logic [1:0] {StRun, StGated, StPend, StWake} state_e;

    state_e           state_q [NumDomains];
    state_e           state_d [NumDomains];
    logic [IdleW-1:0] idle_q  [NumDomains];
    logic [IdleW-1:0] idle_d  [NumDomains];
    logic [WakeW-1:0] wake_q  [NumDomains];
    logic [WakeW-1:0] wake_d  [NumDomains];

    logic [NumDomains-1:0] en_q, en_d;
    logic [NumDomains-1:0] quiet, pend, grant;
    logic [PtrW-1:0]       ptr_q, ptr_d;
    logic                  found;

    assign quiet = ~busy_i & ~wake_req_i & {NumDomains{~force_on_i}};
    assign en_o  = en_q;

    // Status decode; ack is masked by reset so it reads 0 while rst_ni is low.
    always_comb begin
        pend       = '0;
        gated_o    = '0;
        wake_ack_o = '0;
        for (int d = 0; d < NumDomains; d++) begin
            pend[d]       = (state_q[d] == StPend);
            gated_o[d]    = (state_q[d] == StGated) || (state_q[d] == StPend);
            wake_ack_o[d] = wake_req_i[d] & (state_q[d] == StRun) & rst_ni;
        end
    end

    // Round-robin grant: first search indices above the pointer, then wrap to 0..ptr.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int d = 0; d < NumDomains; d++) begin
            if (!found && pend[d] && (PtrW'(d) > ptr_q)) begin
                grant[d] = 1'b1;
                ptr_d    = PtrW'(d);
                found    = 1'b1;
            end
        end
        for (int d = 0; d < NumDomains; d++) begin
            if (!found && pend[d] && (PtrW'(d) <= ptr_q)) begin
                grant[d] = 1'b1;
                ptr_d    = PtrW'(d);
                found    = 1'b1;
            end
        end
    end

    // Per-domain next state, counters and enable (enable derived from next state).
    always_comb begin
        for (int d = 0; d < NumDomains; d++) begin
            state_d[d] = state_q[d];
            idle_d[d]  = idle_q[d];
            wake_d[d]  = wake_q[d];
            case (state_q[d])
                StRun: begin
                    // Activity wins over a terminal count.
                    if (!quiet[d]) begin
                        idle_d[d] = '0;
                    end else if (idle_q[d] == IdleLast) begin
                        state_d[d] = StGated;
                    end else if (idle_q[d] != IdleMax) begin
                        idle_d[d] = idle_q[d] + 1'b1;
                    end
                end
                StGated: begin
                    if (!quiet[d]) state_d[d] = StPend;
                end
                StPend: begin
                    if (grant[d]) begin
                        state_d[d] = StWake;
                        wake_d[d]  = '0;
                    end
                end
                StWake: begin
                    // busy/wake_req are ignored until the wake sequence completes.
                    if (wake_q[d] == WakeLast) begin
                        state_d[d] = StRun;
                        idle_d[d]  = '0;
                    end else begin
                        wake_d[d] = wake_q[d] + 1'b1;
                    end
                end
                default: state_d[d] = StRun;
            endcase
            en_d[d] = (state_d[d] == StRun) || (state_d[d] == StWake);
        end
    end

    // State, counters, pointer and the glitch-free enable flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int d = 0; d < NumDomains; d++) begin
                state_q[d] <= StRun;
                idle_q[d]  <= '0;
                wake_q[d]  <= '0;
            end
            en_q  <= '1;
            ptr_q <= PtrInit;
        end else begin
            for (int d = 0; d < NumDomains; d++) begin
                state_q[d] <= state_d[d];
                idle_q[d]  <= idle_d[d];
                wake_q[d]  <= wake_d[d];
            end
            en_q  <= en_d;
            ptr_q <= ptr_d;
        end
    end

endmodule
